multibank_read_streamer: RTL and testbench

- Read-side sequencer placed directly upstream of the multi-bank BRAM read port (port B).
- Accepts one burst command (start row, length), drives `enb`/`addrb` to all banks in lockstep, and collects `doutb`/`validb`.
- Emits one `BANKS*WIDTH`-bit beat per row on a valid/ready stream, with `last` on the final beat.
- A credit-limited output FIFO absorbs the fixed BRAM read latency so downstream backpressure never loses data.

---
 rtl/multibank_read_streamer_pkg.sv | 22 ++
 rtl/multibank_read_streamer_stream_fifo.sv | 58 +++++
 rtl/multibank_read_streamer.sv | 168 ++++++++++++++++
 tb/tb_multibank_read_streamer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multibank_read_streamer_pkg.sv
// Shared types and constants for the multi-bank read streamer.
// State encodings, default geometry and a ceil-log2 helper.
package multibank_read_streamer_pkg;

    localparam int unsigned DEF_BANKS = 4;
    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_DEPTH = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int unsigned log2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/multibank_read_streamer_stream_fifo.sv
// Single-clock first-word-fall-through FIFO for the read streamer.
// DEPTH must be a power of two so the pointers wrap naturally.
module stream_fifo
    import multibank_read_streamer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = log2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (do_push) begin
                mem_q[wr_q] <= din;
                wr_q        <= wr_q + AW'(1);
            end
            if (do_pop) rd_q <= rd_q + AW'(1);
        end
    end

endmodule

// File: rtl/multibank_read_streamer.sv
// Burst read sequencer for a multi-bank BRAM port B with credit-limited FIFO.
// Optional lane consistency checker: MULTIBANK_READ_STREAMER_LANE_CHECK_EN.
module multibank_read_streamer
    import multibank_read_streamer_pkg::*;
#(
    parameter int BANKS      = DEF_BANKS,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR       = log2(DEPTH),
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ADDR-1:0]        cmd_addr,
    input  logic [ADDR:0]          cmd_len,
    output logic [BANKS-1:0]       enb,
    output logic [BANKS*ADDR-1:0]  addrb,
    input  logic [BANKS*WIDTH-1:0] doutb,
    input  logic [BANKS-1:0]       validb,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [BANKS*WIDTH-1:0] m_data,
    output logic                   m_last,
    output logic                   busy,
    output logic                   done
`ifdef MULTIBANK_READ_STREAMER_LANE_CHECK_EN
    ,
    output logic                   lane_err
`endif
);

    localparam int DW = BANKS * WIDTH;
    localparam int CW = log2(FIFO_DEPTH) + 1;
    localparam logic [ADDR:0] LEN_ONE = (ADDR+1)'(1);

    if (LATENCY < 1 || LATENCY > 4 || FIFO_DEPTH < LATENCY + 1) begin : g_bad_cfg
        $error("LATENCY must be 1..4 and FIFO_DEPTH >= LATENCY+1");
    end

    state_e          state_q, state_d;
    logic [ADDR-1:0] row_q, row_d;
    logic [ADDR:0]   left_q, left_d;
    logic [ADDR:0]   resp_q, resp_d;
    logic [CW-1:0]   out_q, out_d;
    logic            done_q, done_d;

    logic            accept, issue, resp, pop;
    logic [CW-1:0]   fcount;
    logic [CW:0]     used;
    logic            f_empty, f_full;
    logic [DW:0]     f_dout;

    assign accept = cmd_valid && cmd_ready;
    assign resp   = validb[0] && (out_q != '0);
    assign used   = {1'b0, out_q} + {1'b0, fcount};
    assign issue  = (state_q == ST_ISSUE) && (left_q != '0)
                 && (used < (CW+1)'(FIFO_DEPTH));
    assign pop    = m_valid && m_ready;

    assign cmd_ready = (state_q == ST_IDLE) && rst_n;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign enb       = {BANKS{issue}};
    assign addrb     = issue ? {BANKS{row_q}} : '0;

    assign m_valid = !f_empty;
    assign m_data  = m_valid ? f_dout[DW-1:0] : '0;
    assign m_last  = m_valid && f_dout[DW];

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        left_d  = left_q;
        resp_d  = resp_q;
        done_d  = 1'b0;
        out_d   = out_q;
        unique case ({issue, resp})
            2'b10:   out_d = out_q + CW'(1);
            2'b01:   out_d = out_q - CW'(1);
            default: out_d = out_q;
        endcase
        if (resp) resp_d = resp_q - LEN_ONE;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    row_d  = cmd_addr;
                    left_d = cmd_len;
                    resp_d = cmd_len;
                    if (cmd_len == '0) done_d = 1'b1;
                    else state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue) begin
                    row_d  = row_q + ADDR'(1);
                    left_d = left_q - LEN_ONE;
                    if (left_q == LEN_ONE) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // the last-flagged beat leaving the FIFO ends the burst
                if (pop && m_last) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            left_q  <= '0;
            resp_q  <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            left_q  <= left_d;
            resp_q  <= resp_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    stream_fifo #(
        .WIDTH(DW + 1),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (resp),
        .din  ({(resp_q == LEN_ONE), doutb}),
        .pop  (pop),
        .dout (f_dout),
        .empty(f_empty),
        .full (f_full),
        .count(fcount)
    );

`ifdef MULTIBANK_READ_STREAMER_LANE_CHECK_EN
    logic lane_err_q;
    logic unused_full;
    assign unused_full = f_full;
    assign lane_err    = lane_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_err_q <= 1'b0;
        end else if (((validb != '0) && (validb != '1))
                  || (validb[0] && (out_q == '0))) begin
            lane_err_q <= 1'b1;
        end else if (accept) begin
            lane_err_q <= 1'b0;
        end
    end
`else
    logic unused_vb;
    assign unused_vb = ^{validb[BANKS-1:1], f_full};
`endif

endmodule

// File: tb/tb_multibank_read_streamer.sv
// Scoreboard bench for multibank_read_streamer with a 2-cycle BRAM model.
// Covers full-rate, wrap, backpressure, zero-length, mid-burst reset.
module tb_multibank_read_streamer;

    localparam int BANKS = 4;
    localparam int WIDTH = 16;
    localparam int DEPTH = 256;
    localparam int ADDR  = 8;
    localparam int DW    = BANKS * WIDTH;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR-1:0]       cmd_addr;
    logic [ADDR:0]         cmd_len;
    logic [BANKS-1:0]      enb;
    logic [BANKS*ADDR-1:0] addrb;
    logic [DW-1:0]         doutb;
    logic [BANKS-1:0]      validb;
    logic                  m_valid;
    logic                  m_ready;
    logic [DW-1:0]         m_data;
    logic                  m_last;
    logic                  busy;
    logic                  done;
`ifdef MULTIBANK_READ_STREAMER_LANE_CHECK_EN
    logic                  lane_err;
`endif

    always #5 clk = ~clk;

    multibank_read_streamer #(
        .BANKS(BANKS), .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR),
        .LATENCY(2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .enb(enb), .addrb(addrb), .doutb(doutb), .validb(validb),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done)
`ifdef MULTIBANK_READ_STREAMER_LANE_CHECK_EN
        , .lane_err(lane_err)
`endif
    );

    // BRAM model: two register stages, each bank addressed by its own lane
    logic                  v1 = 1'b0, v2 = 1'b0;
    logic [BANKS*ADDR-1:0] a1 = '0, a2 = '0;
    logic                  force_lane = 1'b0;

    always @(posedge clk) begin
        v1 <= enb[0];
        a1 <= addrb;
        v2 <= v1;
        a2 <= a1;
    end

    always_comb begin
        doutb = '0;
        for (int i = 0; i < BANKS; i++)
            doutb[i*WIDTH +: WIDTH] = {4'(i), 4'h0, a2[i*ADDR +: ADDR]};
    end

    assign validb = force_lane ? 4'b0111 : {BANKS{v2}};

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [DW:0] got,
                         input logic [DW:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW:0] beat(input int r, input bit last);
        logic [DW:0] b;
        b[DW] = last;
        for (int i = 0; i < BANKS; i++)
            b[i*WIDTH +: WIDTH] = {4'(i), 4'h0, 8'(r)};
        return b;
    endfunction

    logic [DW:0] exp_q[$];
    logic [DW:0] e_q;
    int cyc = 0;
    int first_enb, first_beat, last_beat, beats, vcnt;
    int done_cnt, done_cyc, enb_cnt, inflight, maxfl;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (enb != '0) begin
                check("enb_lanes", {61'd0, enb}, {61'd0, 4'hf});
                if (first_enb < 0) first_enb = cyc;
                enb_cnt++;
                inflight++;
            end
            if (inflight > maxfl) maxfl = inflight;
            if (m_valid) vcnt++;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", {m_last, m_data}, '0);
                end else begin
                    e_q = exp_q.pop_front();
                    check("beat", {m_last, m_data}, e_q);
                end
                if (first_beat < 0) first_beat = cyc;
                last_beat = cyc;
                beats++;
                inflight--;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clr();
        first_enb = -1; first_beat = -1; last_beat = 0;
        beats = 0; vcnt = 0; done_cnt = 0; done_cyc = 0;
        enb_cnt = 0; inflight = 0; maxfl = 0;
    endtask

    task automatic send(input int a, input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < n; i++) exp_q.push_back(beat(a + i, i == n - 1));
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ready_timeout", 0, 1);
        @(posedge clk) #1;
        cmd_valid = 1'b1;
        cmd_addr  = 8'(a);
        cmd_len   = 9'(n);
        @(posedge clk) #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done_cnt > 0) return;
        end
        check("done_timeout", 0, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, cmd_ready, 0);
        check({tag, "_enb"}, enb, 0);
        check({tag, "_addrb"}, addrb, 0);
        check({tag, "_mvalid"}, m_valid, 0);
        check({tag, "_mlast"}, m_last, 0);
        check({tag, "_mdata"}, m_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
`ifdef MULTIBANK_READ_STREAMER_LANE_CHECK_EN
        check({tag, "_lane_err"}, lane_err, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        m_ready = 1'b1;
        clr();
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk) #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", cmd_ready, 1);

        // full-rate burst, plus a command that must be ignored while busy
        clr();
        send(10, 8);
        @(negedge clk);
        check("busy", busy, 1);
        check("ready_busy", cmd_ready, 0);
        @(posedge clk) #1;
        cmd_valid = 1'b1; cmd_addr = 8'd99; cmd_len = 9'd3;
        @(posedge clk) #1;
        cmd_valid = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);
        check("b1_beats", beats, 8);
        check("b1_latency", first_beat - first_enb, 3);
        check("b1_consecutive", last_beat - first_beat, 7);
        check("b1_done_cyc", done_cyc, last_beat + 1);
        check("b1_done_cnt", done_cnt, 1);
        check("b1_empty", exp_q.size(), 0);

        // address wrap
        clr();
        send(254, 4);
        wait_done();
        repeat (3) @(negedge clk);
        check("wrap_beats", beats, 4);
        check("wrap_empty", exp_q.size(), 0);

        // backpressure
        clr();
        m_ready = 1'b0;
        send(100, 16);
        repeat (20) @(posedge clk);
        #1;
        check("bp_stall_issues", enb_cnt, 4);
        for (int k = 0; k < 300; k++) begin
            @(posedge clk) #1;
            m_ready = ~m_ready;
            if (done_cnt > 0) break;
        end
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("bp_done_cnt", done_cnt, 1);
        check("bp_beats", beats, 16);
        check("bp_credit", maxfl, 4);
        check("bp_empty", exp_q.size(), 0);

        // zero-length command
        clr();
        send(5, 0);
        @(negedge clk);
        check("z_done", done, 1);
        check("z_ready", cmd_ready, 1);
        repeat (5) @(negedge clk);
        check("z_done_cnt", done_cnt, 1);
        check("z_enb", enb_cnt, 0);
        check("z_mvalid", vcnt, 0);

        // reset with two reads in flight
        clr();
        send(50, 8);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (enb_cnt >= 2) break;
        end
        @(posedge clk) #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(posedge clk) #1;
        rst_n = 1'b1;
        exp_q.delete();
        clr();
        send(0, 2);
        wait_done();
        repeat (3) @(negedge clk);
        check("post_rst_beats", beats, 2);
        check("post_rst_empty", exp_q.size(), 0);

`ifdef MULTIBANK_READ_STREAMER_LANE_CHECK_EN
        clr();
        @(posedge clk) #1;
        force_lane = 1'b1;
        @(posedge clk) #1;
        force_lane = 1'b0;
        @(negedge clk);
        check("lane_set", lane_err, 1);
        repeat (3) @(negedge clk);
        check("lane_sticky", lane_err, 1);
        send(20, 1);
        @(negedge clk);
        check("lane_clear", lane_err, 0);
        wait_done();
        repeat (2) @(negedge clk);
        check("lane_beats", beats, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
